bram_copy: RTL

BRAM_COPY -- requirements
Module: bram_copy

---
 rtl/bram_copy_pkg.sv | 10 +
 rtl/bram_copy.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bram_copy_pkg.sv
// Shared types for the block-RAM copy engine: FSM state encoding.
package bram_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bram_copy.sv
// Block-RAM copy engine: streams len words from src to dst through one RAM read and one RAM write port.
// Optional macro BRAM_COPY_FILL_EN adds a fill mode that writes a constant instead of copied data.
module bram_copy
  import bram_copy_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [AW:0]      len,
`ifdef BRAM_COPY_FILL_EN
  input  logic             fill_mode,
  input  logic [WIDTH-1:0] fill_value,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr_write,
  output logic [AW-1:0]    mem_addr_read,
  output logic [WIDTH-1:0] mem_data_out,
  input  logic [WIDTH-1:0] mem_data_in
);

  state_t          state_reg, state_next;
  logic [AW-1:0]   rd_addr_reg, wr_addr_reg;
  logic [AW:0]     len_reg, rd_cnt_reg, wr_cnt_reg;
  logic            we_reg;
  logic            fill_active;
  logic [WIDTH-1:0] fill_data;

`ifdef BRAM_COPY_FILL_EN
  logic             fill_reg;
  logic [WIDTH-1:0] fill_value_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_reg       <= 1'b0;
      fill_value_reg <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      fill_reg       <= fill_mode;
      fill_value_reg <= fill_value;
    end
  end

  assign fill_active = fill_reg;
  assign fill_data   = fill_value_reg;
`else
  assign fill_active = 1'b0;
  assign fill_data   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // COPY ends once the last write has been presented for a full cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? ST_DONE : ST_COPY;
        end
      end
      ST_COPY: begin
        if (we_reg && wr_cnt_reg == len_reg) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reads lead writes by one cycle to cover the RAM's registered read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      len_reg     <= '0;
      rd_cnt_reg  <= '0;
      wr_cnt_reg  <= '0;
      we_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          we_reg <= 1'b0;
          if (start && len != '0) begin
            rd_addr_reg <= src;
            wr_addr_reg <= dst;
            len_reg     <= len;
            rd_cnt_reg  <= {{AW{1'b0}}, 1'b1};
            wr_cnt_reg  <= '0;
          end
        end
        ST_COPY: begin
          if (rd_cnt_reg < len_reg) begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
            if (!fill_active) begin
              rd_addr_reg <= rd_addr_reg + 1'b1;
            end
          end
          if (we_reg) begin
            wr_addr_reg <= wr_addr_reg + 1'b1;
          end
          if (wr_cnt_reg < len_reg) begin
            we_reg     <= 1'b1;
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
          end else begin
            we_reg <= 1'b0;
          end
        end
        default: we_reg <= 1'b0;
      endcase
    end
  end

  always_comb begin
    busy           = (state_reg == ST_COPY);
    done           = (state_reg == ST_DONE);
    mem_we         = we_reg;
    mem_addr_read  = rd_addr_reg;
    mem_addr_write = wr_addr_reg;
    mem_data_out   = fill_active ? fill_data : mem_data_in;
  end

endmodule
